// File: rtl/branch_unit.sv
// Control-flow resolver for relative branches, JMP abs and JMP (ind).
// Emits a one-cycle registered redirect pulse toward the PC register.
module branch_unit #(
   parameter int ADDR_W = 16
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        op_i,
   input  logic              cond_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [15:0]       operand_i,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_rvalid_i,
   input  logic [7:0]        mem_rdata_i,
   output logic              taken_branch_o,
   output logic [ADDR_W-1:0] new_pc_o,
   output logic              page_cross_o
);

   // state  | meaning
   // IDLE   | ready for a request; BRANCH/JMP_ABS resolve here
   // RD_LO  | JMP (ind): address-setup cycle, then read target low byte at ptr
   // RD_HI  | JMP (ind): read target high byte at ptr with in-page wrap
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_LO = 2'd1,
      RD_HI = 2'd2
   } state_t;

   localparam logic [1:0] OP_BRANCH  = 2'b00;
   localparam logic [1:0] OP_JMP_ABS = 2'b01;
   localparam logic [1:0] OP_JMP_IND = 2'b10;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [7:0]        r_lo;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_taken;
   logic [ADDR_W-1:0] r_new_pc;
   logic              r_page_cross;

   logic              w_accept;
   logic [ADDR_W-1:0] w_branch_tgt;
   logic [ADDR_W-1:0] w_hi_addr;
   logic              w_page_cross;

   assign req_ready_o    = (r_state == IDLE);
   assign w_accept       = req_valid_i && req_ready_o && !flush_i;
   assign w_branch_tgt   = pc_i + {{(ADDR_W-8){operand_i[7]}}, operand_i[7:0]};
   assign w_page_cross   = (w_branch_tgt[ADDR_W-1:8] != pc_i[ADDR_W-1:8]);
   // NMOS 6502 quirk: the pointer's low byte wraps without carrying into the page
   assign w_hi_addr      = {r_ptr[ADDR_W-1:8], r_ptr[7:0] + 8'd1};

   assign mem_req_o      = r_mem_req;
   assign mem_addr_o     = r_mem_addr;
   assign taken_branch_o = r_taken;
   assign new_pc_o       = r_new_pc;
   assign page_cross_o   = r_page_cross;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_lo         <= '0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_taken      <= 1'b0;
         r_new_pc     <= '0;
         r_page_cross <= 1'b0;
      end else begin
         r_taken      <= 1'b0;
         r_page_cross <= 1'b0;
         if (flush_i) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_accept) begin
                     case (op_i)
                        OP_BRANCH: begin
                           if (cond_i) begin
                              r_taken      <= 1'b1;
                              r_new_pc     <= w_branch_tgt;
                              r_page_cross <= w_page_cross;
                           end
                        end
                        OP_JMP_ABS: begin
                           r_taken  <= 1'b1;
                           r_new_pc <= ADDR_W'(operand_i);
                        end
                        OP_JMP_IND: begin
                           r_ptr      <= ADDR_W'(operand_i);
                           r_mem_addr <= ADDR_W'(operand_i);
                           r_state    <= RD_LO;
                        end
                        default: ;
                     endcase
                  end
               end
               RD_LO: begin
                  if (!r_mem_req) begin
                     r_mem_req <= 1'b1;
                  end else if (mem_rvalid_i) begin
                     r_lo       <= mem_rdata_i;
                     r_mem_addr <= w_hi_addr;
                     r_state    <= RD_HI;
                  end
               end
               RD_HI: begin
                  if (mem_rvalid_i) begin
                     r_taken   <= 1'b1;
                     r_new_pc  <= ADDR_W'({mem_rdata_i, r_lo});
                     r_mem_req <= 1'b0;
                     r_state   <= IDLE;
                  end
               end
               default: begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: branches, JMP abs, JMP (ind) page wrap,
// flush and asynchronous reset, against hand-computed expectations.
module tb_branch_unit;

   logic        clk_i;
   logic        rstn_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  op_i;
   logic        cond_i;
   logic [15:0] pc_i;
   logic [15:0] operand_i;
   logic        flush_i;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_rvalid_i;
   logic [7:0]  mem_rdata_i;
   logic        taken_branch_o;
   logic [15:0] new_pc_o;
   logic        page_cross_o;

   int n_checks;
   int n_errs;

   branch_unit #(.ADDR_W(16)) u_dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .op_i           (op_i),
      .cond_i         (cond_i),
      .pc_i           (pc_i),
      .operand_i      (operand_i),
      .flush_i        (flush_i),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .taken_branch_o (taken_branch_o),
      .new_pc_o       (new_pc_o),
      .page_cross_o   (page_cross_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always_comb begin
      mem_rdata_i = 8'h00;
      case (mem_addr_o)
         16'h02FF: mem_rdata_i = 8'h34;
         16'h0200: mem_rdata_i = 8'h12;
         16'h0300: mem_rdata_i = 8'h56;
         default:  mem_rdata_i = 8'h00;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // JMP (ind) at 0x02FF with a fixed number of wait cycles before each rvalid
   task automatic run_ind(input int waits, input int exp_lat, input string tag);
      int          wc;
      int          lat;
      int          nhs;
      logic        prev_req;
      logic        prev_rv;
      logic [15:0] hs_addr [2];
      wc  = 0;
      lat = 0;
      nhs = 0;
      hs_addr[0] = 16'hxxxx;
      hs_addr[1] = 16'hxxxx;
      op_i = 2'b10; operand_i = 16'h02FF; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      chk({tag, "_ready_after_accept"}, 32'(req_ready_o), 32'd0);
      while (!taken_branch_o && lat < 40) begin
         mem_rvalid_i = mem_req_o && (wc == waits);
         prev_req = mem_req_o;
         prev_rv  = mem_rvalid_i;
         if (prev_rv && nhs < 2) begin
            hs_addr[nhs] = mem_addr_o;
            nhs++;
         end
         step();
         lat++;
         if (prev_req) wc = prev_rv ? 0 : wc + 1;
      end
      mem_rvalid_i = 1'b0;
      chk({tag, "_latency"},   32'(lat), 32'(exp_lat));
      chk({tag, "_rd_addr0"},  32'(hs_addr[0]), 32'h02FF);
      chk({tag, "_rd_addr1"},  32'(hs_addr[1]), 32'h0200);
      chk({tag, "_new_pc"},    32'(new_pc_o), 32'h1234);
      chk({tag, "_pcross"},    32'(page_cross_o), 32'd0);
      chk({tag, "_ready"},     32'(req_ready_o), 32'd1);
      chk({tag, "_memreq"},    32'(mem_req_o), 32'd0);
      step();
      chk({tag, "_pulse_end"}, 32'(taken_branch_o), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rstn_i = 1'b0; req_valid_i = 1'b0; op_i = 2'b00; cond_i = 1'b0;
      pc_i = 16'h0000; operand_i = 16'h0000; flush_i = 1'b0; mem_rvalid_i = 1'b0;
      #23;
      chk("rst_taken",  32'(taken_branch_o), 32'd0);
      chk("rst_newpc",  32'(new_pc_o), 32'd0);
      chk("rst_pcross", 32'(page_cross_o), 32'd0);
      chk("rst_memreq", 32'(mem_req_o), 32'd0);
      chk("rst_memaddr",32'(mem_addr_o), 32'd0);
      chk("rst_ready",  32'(req_ready_o), 32'd1);
      @(negedge clk_i);
      rstn_i = 1'b1;
      step();

      // forward taken branch
      op_i = 2'b00; cond_i = 1'b1; pc_i = 16'h8010; operand_i = 16'hAA05; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      chk("fwd_taken",  32'(taken_branch_o), 32'd1);
      chk("fwd_newpc",  32'(new_pc_o), 32'h8015);
      chk("fwd_pcross", 32'(page_cross_o), 32'd0);
      chk("fwd_ready",  32'(req_ready_o), 32'd1);
      step();
      chk("fwd_pulse_end", 32'(taken_branch_o), 32'd0);
      chk("fwd_hold_pc",   32'(new_pc_o), 32'h8015);

      // backward page-crossing branch, then not-taken
      pc_i = 16'h8002; operand_i = 16'h00FC; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      chk("bwd_taken",  32'(taken_branch_o), 32'd1);
      chk("bwd_newpc",  32'(new_pc_o), 32'h7FFE);
      chk("bwd_pcross", 32'(page_cross_o), 32'd1);
      step();
      chk("bwd_pcross_end", 32'(page_cross_o), 32'd0);
      cond_i = 1'b0; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      chk("nt_taken", 32'(taken_branch_o), 32'd0);
      chk("nt_ready", 32'(req_ready_o), 32'd1);
      chk("nt_newpc", 32'(new_pc_o), 32'h7FFE);

      // wrap-around branch followed back-to-back by JMP abs
      cond_i = 1'b1; pc_i = 16'hFFFE; operand_i = 16'h0005; req_valid_i = 1'b1;
      step();
      chk("wrap_newpc",  32'(new_pc_o), 32'h0003);
      chk("wrap_pcross", 32'(page_cross_o), 32'd1);
      op_i = 2'b01; operand_i = 16'hC000;
      step();
      req_valid_i = 1'b0;
      chk("jabs_taken",  32'(taken_branch_o), 32'd1);
      chk("jabs_newpc",  32'(new_pc_o), 32'hC000);
      chk("jabs_pcross", 32'(page_cross_o), 32'd0);
      step();

      // reserved op: accepted, nothing happens
      op_i = 2'b11; operand_i = 16'h02FF; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      chk("rsv_taken",  32'(taken_branch_o), 32'd0);
      chk("rsv_ready",  32'(req_ready_o), 32'd1);
      step();
      chk("rsv_memreq", 32'(mem_req_o), 32'd0);

      run_ind(0, 3, "ind0");
      run_ind(2, 7, "ind2");

      // flush in RD_HI together with rvalid
      op_i = 2'b10; operand_i = 16'h02FF; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      step();
      chk("fl_memreq_on", 32'(mem_req_o), 32'd1);
      mem_rvalid_i = 1'b1;
      step();
      chk("fl_rdhi_addr", 32'(mem_addr_o), 32'h0200);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0; mem_rvalid_i = 1'b0;
      chk("fl_taken",  32'(taken_branch_o), 32'd0);
      chk("fl_memreq", 32'(mem_req_o), 32'd0);
      chk("fl_ready",  32'(req_ready_o), 32'd1);
      chk("fl_newpc",  32'(new_pc_o), 32'h1234);
      mem_rvalid_i = 1'b1;
      step();
      mem_rvalid_i = 1'b0;
      chk("late_rv_taken",  32'(taken_branch_o), 32'd0);
      chk("late_rv_memreq", 32'(mem_req_o), 32'd0);
      // request during flush is not accepted
      op_i = 2'b01; operand_i = 16'h4444; req_valid_i = 1'b1; flush_i = 1'b1;
      step();
      req_valid_i = 1'b0; flush_i = 1'b0;
      chk("flreq_taken", 32'(taken_branch_o), 32'd0);
      chk("flreq_newpc", 32'(new_pc_o), 32'h1234);

      // asynchronous reset in RD_LO
      op_i = 2'b10; operand_i = 16'h02FF; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      step();
      chk("ar_memreq_before", 32'(mem_req_o), 32'd1);
      #2;
      rstn_i = 1'b0;
      #1;
      chk("ar_memreq", 32'(mem_req_o), 32'd0);
      chk("ar_memaddr",32'(mem_addr_o), 32'd0);
      chk("ar_newpc",  32'(new_pc_o), 32'd0);
      chk("ar_taken",  32'(taken_branch_o), 32'd0);
      chk("ar_ready",  32'(req_ready_o), 32'd1);
      #2;
      rstn_i = 1'b1;
      step();
      op_i = 2'b00; cond_i = 1'b1; pc_i = 16'h1000; operand_i = 16'h0010; req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      chk("post_rst_taken",  32'(taken_branch_o), 32'd1);
      chk("post_rst_newpc",  32'(new_pc_o), 32'h1010);
      chk("post_rst_pcross", 32'(page_cross_o), 32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
